// File: rtl/divider.sv
// divider: sequential unsigned restoring divider, one quotient bit per clock.
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor. Results are held in
// output registers from one completed operation until the next.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   start_i       operation request, accepted only while idle
//   dividend_i    2*WIDTH unsigned dividend, captured on accept
//   divisor_i     WIDTH unsigned divisor, captured on accept
//   busy_o        operation in flight (CALC or DONE)
//   done_o        one-cycle pulse, results valid
//   quotient_o    2*WIDTH unsigned quotient
//   remainder_o   WIDTH unsigned remainder
//   div_by_zero_o set together with done_o when the divisor was zero
module divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [2*WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0]   remainder_o,
    output logic               div_by_zero_o
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(DW) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   prem_q, prem_d;     // partial remainder, extra bit for carry
    logic [DW-1:0]    dsh_q, dsh_d;       // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DW-1:0]    quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dzo_q, dzo_d;

    // One restoring step: shift left, trial-subtract the divisor.
    logic [WIDTH:0] trial_c;
    logic [WIDTH:0] diff_c;
    logic           fits_c;

    assign trial_c = {prem_q[WIDTH-1:0], dsh_q[DW-1]};
    assign fits_c  = (trial_c >= {1'b0, dvs_q});
    assign diff_c  = trial_c - {1'b0, dvs_q};

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        dsh_d   = dsh_q;
        dvs_d   = dvs_q;
        dz_d    = dz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dzo_d   = dzo_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start_i) begin
                    state_d = S_CALC;
                    busy_d  = 1'b1;
                    dvs_d   = divisor_i;
                    dsh_d   = dividend_i;
                    prem_d  = '0;
                    dz_d    = (divisor_i == '0);
                    // A zero divisor skips the iterations but still spends one
                    // cycle in CALC, so both paths enter DONE the same way.
                    cnt_d   = (divisor_i == '0) ? '0 : CW'(DW);
                end
            end
            S_CALC: begin
                if (cnt_q != '0) begin
                    cnt_d  = cnt_q - CW'(1);
                    prem_d = fits_c ? diff_c : trial_c;
                    dsh_d  = {dsh_q[DW-2:0], fits_c};
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (dz_q) begin
                        quot_d = '1;
                        rem_d  = '0;
                        dzo_d  = 1'b1;
                    end else begin
                        quot_d = dsh_q;
                        rem_d  = prem_q[WIDTH-1:0];
                        dzo_d  = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dsh_q   <= '0;
            dvs_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            dsh_q   <= dsh_d;
            dvs_q   <= dvs_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dzo_q   <= dzo_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dzo_q;

endmodule

// File: tb/tb_divider.sv
// tb_divider: directed self-checking bench for divider (WIDTH=8).
module tb_divider;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [15:0] dividend_i;
    logic [7:0]  divisor_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] quotient_o;
    logic [7:0]  remainder_o;
    logic        div_by_zero_o;

    int checks = 0;
    int errors = 0;

    divider #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present operands for one edge; scramble them afterwards.
    task automatic issue(input logic [15:0] dvd, input logic [7:0] dvs);
        @(negedge clk);
        start_i    = 1'b1;
        dividend_i = dvd;
        divisor_i  = dvs;
        @(posedge clk);
        #1;
        start_i    = 1'b0;
        dividend_i = 16'hBEEF;
        divisor_i  = 8'h00;
    endtask

    // Edges from accept until done rises, bounded at 40.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            lat = i;
            if (done_o) break;
        end
    endtask

    task automatic op(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                      input logic [15:0] eq, input logic [7:0] er, input logic edz,
                      input int elat);
        int lat;
        issue(dvd, dvs);
        check({tag, "_busy_accept"}, 32'(busy_o), 32'd1);
        wait_done(lat);
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_quotient"}, 32'(quotient_o), 32'(eq));
        check({tag, "_remainder"}, 32'(remainder_o), 32'(er));
        check({tag, "_dbz"}, 32'(div_by_zero_o), 32'(edz));
        check({tag, "_busy_done"}, 32'(busy_o), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, 32'(done_o), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int ndone;
        int lat;

        rst_n      = 1'b0;
        start_i    = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_quot", 32'(quotient_o), 32'd0);
        check("rst_rem", 32'(remainder_o), 32'd0);
        check("rst_dbz", 32'(div_by_zero_o), 32'd0);
        rst_n = 1'b1;

        op("d100_10", 16'd100, 8'd10, 16'd10, 8'd0, 1'b0, 17);
        op("d1000_7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 17);
        op("d65535_255", 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 17);
        op("d5_9", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 17);

        for (int a = 1; a <= 10; a++) begin
            for (int b = 1; b <= 10; b++) begin
                op("sweep", 16'(a * b), 8'(b), 16'(a), 8'd0, 1'b0, 17);
            end
        end

        op("dz_1234", 16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1, 1);
        op("d9_2", 16'd9, 8'd2, 16'd4, 8'd1, 1'b0, 17);

        // Second start at cycle 5 lands while busy and must be dropped.
        issue(16'd200, 8'd3);
        ndone = 0;
        lat   = 0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 5) begin
                start_i    = 1'b1;
                dividend_i = 16'd50;
                divisor_i  = 8'd5;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done_o) begin
                ndone++;
                lat = k;
            end
        end
        start_i = 1'b0;
        check("ign_ndone", 32'(ndone), 32'd1);
        check("ign_latency", 32'(lat), 32'd17);
        check("ign_quot", 32'(quotient_o), 32'd66);
        check("ign_rem", 32'(remainder_o), 32'd2);
        check("ign_busy_end", 32'(busy_o), 32'd0);

        // Reset at cycle 8 of an operation aborts it.
        issue(16'd200, 8'd3);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        check("abort_busy_pre", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_quot", 32'(quotient_o), 32'd0);
        check("abort_rem", 32'(remainder_o), 32'd0);
        check("abort_dbz", 32'(div_by_zero_o), 32'd0);
        ndone = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done_o) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);

        op("d81_9", 16'd81, 8'd9, 16'd9, 8'd0, 1'b0, 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
